// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: issues in-order imem requests and holds up to two
// returned instructions for decode, dropping stale responses after a redirect.
//
// state | meaning
// RUN   | normal fetch; responses fill the instruction buffer
// DRAIN | after a flush, discard the responses still in flight (drop_q of them)
module ifetch_buf #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        stall,
  output logic        fetch_fire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_err
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  occ_q, occ_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic        fetch_err_q, fetch_err_d;

  // Both FIFOs are two entries deep, so a single toggling bit is the pointer.
  logic [31:0] pcf_q [BUF_DEPTH];
  logic [31:0] pcf_d [BUF_DEPTH];
  logic        pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
  logic [31:0] ib_pc_q [BUF_DEPTH];
  logic [31:0] ib_pc_d [BUF_DEPTH];
  logic [31:0] ib_data_q [BUF_DEPTH];
  logic [31:0] ib_data_d [BUF_DEPTH];
  logic        ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;

  logic        rsp_live;
  logic        ib_push;
  logic        ib_pop;

  assign imem_req   = (state_q == RUN) & ~stall & ~flush &
                      ((3'(outst_q) + 3'(occ_q)) < 3'(BUF_DEPTH));
  assign fetch_fire = imem_req & imem_gnt;
  assign imem_addr  = {pc[31:2], 2'b00};

  assign inst_valid = (occ_q != 2'd0);
  assign inst       = ib_data_q[ib_rd_q];
  assign inst_pc    = ib_pc_q[ib_rd_q];
  assign fetch_err  = fetch_err_q;

  assign rsp_live = imem_rvalid & (outst_q != 2'd0);
  assign ib_push  = (state_q == RUN) & ~flush & rsp_live;
  assign ib_pop   = (state_q == RUN) & ~flush & inst_valid & inst_ready;

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    pcf_d       = pcf_q;
    pcf_wr_d    = pcf_wr_q;
    pcf_rd_d    = pcf_rd_q;
    ib_pc_d     = ib_pc_q;
    ib_data_d   = ib_data_q;
    ib_wr_d     = ib_wr_q;
    ib_rd_d     = ib_rd_q;
    fetch_err_d = fetch_err_q | (imem_rvalid & (outst_q == 2'd0) & (drop_q == 2'd0));

    if (state_q == RUN) begin
      if (flush) begin
        occ_d    = 2'd0;
        outst_d  = 2'd0;
        pcf_wr_d = 1'b0;
        pcf_rd_d = 1'b0;
        ib_wr_d  = 1'b0;
        ib_rd_d  = 1'b0;
        // A response landing in the flush cycle is already consumed here.
        drop_d   = outst_q - {1'b0, rsp_live};
        if (drop_d != 2'd0) state_d = DRAIN;
      end else begin
        if (ib_push) begin
          ib_pc_d[ib_wr_q]   = pcf_q[pcf_rd_q];
          ib_data_d[ib_wr_q] = imem_rdata;
          ib_wr_d            = ~ib_wr_q;
          pcf_rd_d           = ~pcf_rd_q;
        end
        if (ib_pop) ib_rd_d = ~ib_rd_q;
        if (fetch_fire) begin
          pcf_d[pcf_wr_q] = pc;
          pcf_wr_d        = ~pcf_wr_q;
        end
        occ_d   = occ_q + {1'b0, ib_push} - {1'b0, ib_pop};
        outst_d = outst_q + {1'b0, fetch_fire} - {1'b0, ib_push};
      end
    end else begin
      if (flush) begin
        occ_d   = 2'd0;
        ib_wr_d = 1'b0;
        ib_rd_d = 1'b0;
      end
      if (imem_rvalid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
        if (drop_d == 2'd0) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      occ_q       <= 2'd0;
      outst_q     <= 2'd0;
      drop_q      <= 2'd0;
      fetch_err_q <= 1'b0;
      pcf_wr_q    <= 1'b0;
      pcf_rd_q    <= 1'b0;
      ib_wr_q     <= 1'b0;
      ib_rd_q     <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pcf_q[i]     <= 32'd0;
        ib_pc_q[i]   <= 32'd0;
        ib_data_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      fetch_err_q <= fetch_err_d;
      pcf_wr_q    <= pcf_wr_d;
      pcf_rd_q    <= pcf_rd_d;
      ib_wr_q     <= ib_wr_d;
      ib_rd_q     <= ib_rd_d;
      pcf_q       <= pcf_d;
      ib_pc_q     <= ib_pc_d;
      ib_data_q   <= ib_data_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch buffer and an in-order memory.
module tb_ifetch_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  logic        flush, stall, imem_gnt, imem_rvalid, inst_ready;
  logic [31:0] imem_rdata;
  logic        fetch_fire, imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, inst, inst_pc;

  always #5 clk = ~clk;

  ifetch_buf #(.BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .flush      (flush),
    .stall      (stall),
    .fetch_fire (fetch_fire),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: requests in flight, buffered {pc,data}, responses to drop.
  logic [31:0] m_infl[$];
  logic [63:0] m_buf[$];
  int          m_drop;
  bit          m_drain;
  bit          m_err;
  bit          last_fire;

  // Memory model: granted addresses returned in order, each no earlier than its due cycle.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_infl.delete();
    m_buf.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    m_drop  = 0;
    m_drain = 0;
    m_err   = 0;
  endtask

  task automatic step(input bit fl, input bit st, input bit rdy, input bit g, input bit rv,
                      input logic [31:0] rd, input logic [31:0] p);
    bit          exp_req;
    bit          exp_fire;
    logic [31:0] head_pc;
    flush = fl; stall = st; inst_ready = rdy; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; pc = p;
    #2;
    exp_req  = !m_drain && !st && !fl && (m_infl.size() + m_buf.size() < 2);
    exp_fire = exp_req && g;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("fetch_fire", {31'd0, fetch_fire}, {31'd0, exp_fire});
    chk("imem_addr", imem_addr, {p[31:2], 2'b00});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_buf.size() != 0)});
    if (m_buf.size() != 0) begin
      chk("inst", inst, m_buf[0][31:0]);
      chk("inst_pc", inst_pc, m_buf[0][63:32]);
    end
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});

    if (m_drain) begin
      if (rv) begin
        m_drop--;
        if (m_drop == 0) m_drain = 0;
      end
      if (fl) m_buf.delete();
    end else if (fl) begin
      if (rv && m_infl.size() == 0) m_err = 1;
      m_drop  = m_infl.size() - ((rv && m_infl.size() != 0) ? 1 : 0);
      m_drain = (m_drop != 0);
      m_buf.delete();
      m_infl.delete();
    end else begin
      if (rdy && m_buf.size() != 0) void'(m_buf.pop_front());
      if (rv) begin
        if (m_infl.size() == 0) m_err = 1;
        else begin
          head_pc = m_infl.pop_front();
          m_buf.push_back({head_pc, rd});
        end
      end
      if (exp_fire) m_infl.push_back(p);
    end

    if (rv && mem_addr_q.size() != 0) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (exp_fire) begin
      mem_addr_q.push_back(p);
      mem_due_q.push_back(cyc + 1 + int'($urandom_range(0, 2)));
    end
    last_fire = exp_fire;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          fl, st, rdy, g, rv, idle;
    logic [31:0] rd, cur_pc;

    pc = 32'd0; flush = 0; stall = 1; inst_ready = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'd0;
    model_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    stall = 0;
    #1 chk("rst_req_unstalled", {31'd0, imem_req}, 32'd1);
    stall = 1;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // First fetch: grant, response next cycle, visible the cycle after.
    step(0, 0, 0, 1, 0, 32'd0, 32'h0);
    step(0, 1, 0, 0, 1, 32'h0000_0013, 32'h4);
    chk("t1_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h0000_0013);
    chk("t1_pc", inst_pc, 32'h0);
    step(0, 1, 1, 0, 0, 32'd0, 32'h4);

    // Buffer fills with decode held, then one pop reopens the request path.
    step(0, 0, 0, 1, 0, 32'd0, 32'h8);
    step(0, 0, 0, 1, 1, memf(32'h8), 32'hC);
    step(0, 0, 0, 0, 1, memf(32'hC), 32'h10);
    chk("t2_full_req", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 1, 0, 32'd0, 32'h10);
    step(0, 0, 1, 1, 0, 32'd0, 32'h10);
    #2 chk("t2_reopen_req", {31'd0, imem_req}, 32'd1);
    #(-2+2);
    step(0, 0, 0, 1, 0, 32'd0, 32'h10);
    step(0, 0, 1, 0, 1, memf(32'h10), 32'h14);
    step(0, 0, 1, 0, 0, 32'd0, 32'h14);

    // Flush with two outstanding: both responses dropped, then refetch at 0x80.
    step(0, 0, 0, 1, 0, 32'd0, 32'h40);
    step(0, 0, 0, 1, 0, 32'd0, 32'h44);
    step(1, 0, 0, 0, 0, 32'd0, 32'h80);
    step(0, 0, 0, 1, 0, 32'd0, 32'h80);
    step(0, 0, 0, 1, 1, memf(32'h40), 32'h80);
    step(0, 0, 0, 1, 1, memf(32'h44), 32'h80);
    chk("t3_req_resume", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h80);
    step(0, 0, 0, 1, 0, 32'd0, 32'h80);
    step(0, 1, 0, 0, 1, memf(32'h80), 32'h84);
    chk("t3_inst_pc", inst_pc, 32'h80);
    step(0, 1, 1, 0, 0, 32'd0, 32'h84);

    // Flush + rvalid + inst_ready together, one outstanding: nothing left to drop.
    step(0, 0, 0, 1, 0, 32'd0, 32'h600);
    step(0, 0, 0, 1, 1, memf(32'h600), 32'h604);
    step(1, 0, 1, 0, 1, memf(32'h604), 32'h700);
    chk("t4_valid_after_flush", {31'd0, inst_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 32'd0, 32'h700);
    // Same with two outstanding: exactly one response left to drop.
    step(0, 0, 0, 1, 0, 32'd0, 32'h700);
    step(0, 0, 0, 1, 0, 32'd0, 32'h704);
    step(1, 0, 1, 0, 1, memf(32'h700), 32'h800);
    step(0, 0, 0, 1, 0, 32'd0, 32'h800);
    step(0, 0, 0, 1, 1, memf(32'h704), 32'h800);
    step(0, 0, 0, 1, 0, 32'd0, 32'h800);
    step(0, 1, 0, 0, 1, memf(32'h800), 32'h804);
    step(0, 1, 1, 0, 0, 32'd0, 32'h804);

    // Randomized traffic against the model.
    cur_pc = 32'h1000;
    for (int i = 0; i < 500; i++) begin
      fl  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      g   = ($urandom_range(0, 3) != 0);
      rv  = (mem_addr_q.size() != 0) && (mem_due_q[0] <= cyc);
      rd  = rv ? memf(mem_addr_q[0]) : $urandom();
      step(fl, st, rdy, g, rv, rd, cur_pc);
      if (fl) cur_pc = $urandom() & 32'hFFFF_FFFC;
      else if (last_fire) cur_pc = cur_pc + 32'd4;
    end
    idle = 0;
    for (int i = 0; i < 60 && !idle; i++) begin
      rv = (mem_addr_q.size() != 0) && (mem_due_q[0] <= cyc);
      rd = rv ? memf(mem_addr_q[0]) : 32'd0;
      step(0, 1, 1, 0, rv, rd, cur_pc);
      idle = (mem_addr_q.size() == 0) && (m_buf.size() == 0) && !m_drain;
    end
    chk("quiesce", {31'd0, idle}, 32'd1);

    // Spurious response: sticky error, buffer untouched.
    step(0, 0, 0, 1, 0, 32'd0, 32'h500);
    step(0, 1, 0, 0, 1, memf(32'h500), 32'h504);
    step(0, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h504);
    chk("t5_err", {31'd0, fetch_err}, 32'd1);
    chk("t5_inst", inst, memf(32'h500));
    chk("t5_inst_pc", inst_pc, 32'h500);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 32'd0, 32'h504);
    chk("t5_err_sticky", {31'd0, fetch_err}, 32'd1);
    step(0, 1, 1, 0, 0, 32'd0, 32'h504);

    // Reset asserted mid-DRAIN, then fetch restarts from pc.
    step(0, 0, 0, 1, 0, 32'd0, 32'h100);
    step(0, 0, 0, 1, 0, 32'd0, 32'h104);
    step(1, 0, 0, 0, 0, 32'd0, 32'h200);
    step(0, 0, 0, 1, 1, memf(32'h100), 32'h200);
    stall = 1; imem_gnt = 0; imem_rvalid = 0; flush = 0; pc = 32'h300;
    rst_n = 0;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_fire", {31'd0, fetch_fire}, 32'd0);
    chk("t6_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_inst", inst, 32'd0);
    chk("t6_inst_pc", inst_pc, 32'd0);
    chk("t6_err", {31'd0, fetch_err}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 0, 32'd0, 32'h300);
    step(0, 1, 0, 0, 1, memf(32'h300), 32'h304);
    chk("t6_restart_valid", {31'd0, inst_valid}, 32'd1);
    chk("t6_restart_pc", inst_pc, 32'h300);
    step(0, 1, 1, 0, 0, 32'd0, 32'h304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, meaning instruction-buffer entries; this revision supports exactly 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pc, input, 32 bits: fetch address from the PC stage.
REQ-005 SHALL have port flush, input, 1 bit: redirect (branch, jump, trap or mret) taken this cycle.
REQ-006 SHALL have port stall, input, 1 bit: back-end hold; while high, no new fetch is issued.
REQ-007 SHALL have port fetch_fire, output, 1 bit: request accepted this cycle; the PC stage advances on it.
REQ-008 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32 bits: request address, equal to {pc[31:2],2'b00}.
REQ-010 SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-011 SHALL have port imem_rvalid, input, 1 bit: response valid; responses return in order, at least 1 cycle after grant.
REQ-012 SHALL have port imem_rdata, input, 32 bits: response instruction word.
REQ-013 SHALL have port inst_valid, output, 1 bit: buffer head valid toward decode.
REQ-014 SHALL have port inst, output, 32 bits: head instruction.
REQ-015 SHALL have port inst_pc, output, 32 bits: head instruction address.
REQ-016 SHALL have port inst_ready, input, 1 bit: decode consumes the head.
REQ-017 SHALL have port fetch_err, output, 1 bit: sticky flag for a response received with no outstanding request.

Function
REQ-018 SHALL implement FSM states RUN and DRAIN; reset state is RUN.
REQ-019 SHALL compute imem_req = (state==RUN) & ~stall & ~flush & (outstanding + occupancy < BUF_DEPTH), combinationally.
REQ-020 SHALL compute fetch_fire = imem_req & imem_gnt; each fire pushes pc into a BUF_DEPTH-deep in-flight PC FIFO and increments outstanding.
REQ-021 SHALL, in RUN, on imem_rvalid, pop the in-flight PC FIFO and write {popped pc, imem_rdata} into the instruction buffer tail, decrementing outstanding.
REQ-022 SHALL drive inst_valid = (occupancy != 0), with inst and inst_pc taken from the head entry, registered with no combinational path from imem_rdata.
REQ-023 SHALL pop the head on inst_valid & inst_ready; a simultaneous push and pop SHALL keep occupancy unchanged, including when the buffer is full.
REQ-024 SHALL make minimum fetch-to-inst_valid latency 2 cycles: grant in cycle N, rvalid in N+1, inst_valid in N+2.
REQ-025 SHALL, on flush, clear the instruction buffer and the in-flight PC FIFO in the next cycle, load drop_cnt with outstanding (less 1 if rvalid arrives in the flush cycle), and enter DRAIN if the result is nonzero, else stay in RUN.
REQ-026 SHALL, in DRAIN, discard each rvalid response and decrement drop_cnt; reaching 0 returns the FSM to RUN the following cycle; no requests are issued in DRAIN.
REQ-027 SHALL give flush priority over inst_ready and rvalid in the same cycle; no entry is pushed or presented after flush.
REQ-028 SHALL treat flush while in DRAIN as clearing the buffer only; drop_cnt is unaffected.
REQ-029 SHALL ignore rvalid with outstanding==0 and drop_cnt==0, and set fetch_err, which holds until reset.
REQ-030 SHALL never let occupancy + outstanding exceed BUF_DEPTH; the counters are 2 bits wide and never wrap.

Reset
REQ-031 SHALL, on rst_n low and asynchronously, force state=RUN, occupancy=0, outstanding=0, drop_cnt=0, inst_valid=0, inst=0, inst_pc=0 and fetch_err=0; imem_req then depends only on stall and flush.
REQ-032 SHALL, when reset asserts mid-transaction, forget responses already in flight; the memory is reset together with this block.

Verification
REQ-033 Bench SHALL cover: pc=0x0, gnt=1, rvalid one cycle later with data 0x00000013 -> inst_valid in cycle 2, inst=0x00000013, inst_pc=0x0.
REQ-034 Bench SHALL cover: inst_ready=0 with two fetches returned -> imem_req=0 while occupancy=2; one pop -> imem_req=1 the next cycle.
REQ-035 Bench SHALL cover: flush with 2 outstanding -> DRAIN; two rvalids discarded; RUN resumes and the first new request uses the redirected pc 0x80.
REQ-036 Bench SHALL cover: flush, rvalid and inst_ready all in the same cycle -> the next cycle inst_valid=0, nothing pushed, drop_cnt=outstanding-1.
REQ-037 Bench SHALL cover: rvalid with nothing outstanding -> fetch_err=1, buffer unchanged, and fetch_err still 1 after 10 cycles.
REQ-038 Bench SHALL cover: rst_n low mid-DRAIN -> all outputs 0 immediately; after release, fetching restarts from pc.
